// File: rtl/axi_lite_mem_resp.sv
// AXI4-Lite responder backed by a word-addressed register array.
// Independent single-cycle read and write paths with one-deep B/R slots.

package axi_lite_mem_resp_pkg;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [2:0]    prot;
    } aw_chan_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
    } w_chan_t;

    typedef struct packed {
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [2:0]    prot;
    } ar_chan_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic     aw_ready;
        logic     w_ready;
        b_chan_t  b;
        logic     b_valid;
        logic     ar_ready;
        r_chan_t  r;
        logic     r_valid;
    } axi_resp_t;

endpackage

module axi_lite_mem_resp
    import axi_lite_mem_resp_pkg::*;
#(
    parameter int unsigned          AddrWidth  = 32,
    parameter int unsigned          DataWidth  = 32,
    parameter int unsigned          NumWords   = 16,
    parameter logic [AddrWidth-1:0] BaseAddr   = '0,
    parameter type                  axi_req_t  = axi_lite_mem_resp_pkg::axi_req_t,
    parameter type                  axi_resp_t = axi_lite_mem_resp_pkg::axi_resp_t
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  axi_req_t  slv_req_i,
    output axi_resp_t slv_resp_o
);

    localparam int unsigned StrbW = DataWidth / 8;
    localparam int unsigned OffW  = $clog2(StrbW);
    localparam int unsigned IdxW  = (NumWords > 1) ? $clog2(NumWords) : 1;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    typedef logic [AddrWidth-1:0] addr_t;
    typedef logic [DataWidth-1:0] data_t;

    function automatic logic is_hit(input addr_t a);
        addr_t off;
        addr_t idx;
        off = a - BaseAddr;
        idx = off >> OffW;
        return (a >= BaseAddr) && (idx < addr_t'(NumWords));
    endfunction

    function automatic logic [IdxW-1:0] word_idx(input addr_t a);
        addr_t off;
        off = a - BaseAddr;
        return IdxW'(off >> OffW);
    endfunction

    data_t           mem_q [NumWords];
    data_t           mem_d [NumWords];
    logic            b_valid_q, b_valid_d;
    logic [1:0]      b_resp_q, b_resp_d;
    logic            r_valid_q, r_valid_d;
    data_t           r_data_q, r_data_d;
    logic [1:0]      r_resp_q, r_resp_d;

    logic            wr_go, rd_go, ar_rdy;
    logic            wr_hit, rd_hit;
    logic [IdxW-1:0] wr_idx, rd_idx;

    assign wr_hit = is_hit(slv_req_i.aw.addr);
    assign rd_hit = is_hit(slv_req_i.ar.addr);
    assign wr_idx = word_idx(slv_req_i.aw.addr);
    assign rd_idx = word_idx(slv_req_i.ar.addr);

    // AW and W are joined; a free or draining B slot lets a write in
    assign wr_go  = !rst_i && slv_req_i.aw_valid && slv_req_i.w_valid
                    && (!b_valid_q || slv_req_i.b_ready);
    assign ar_rdy = !rst_i && (!r_valid_q || slv_req_i.r_ready);
    assign rd_go  = ar_rdy && slv_req_i.ar_valid;

    // Byte-lane merge of the accepted write into the array
    always_comb begin
        mem_d = mem_q;
        if (wr_go && wr_hit) begin
            for (int k = 0; k < StrbW; k++) begin
                if (slv_req_i.w.strb[k]) begin
                    mem_d[wr_idx][8*k +: 8] = slv_req_i.w.data[8*k +: 8];
                end
            end
        end
    end

    // Array storage, cleared on reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumWords; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // B and R slot next state; read sees pre-write array contents
    always_comb begin
        b_valid_d = b_valid_q;
        b_resp_d  = b_resp_q;
        r_valid_d = r_valid_q;
        r_data_d  = r_data_q;
        r_resp_d  = r_resp_q;
        if (wr_go) begin
            b_valid_d = 1'b1;
            b_resp_d  = wr_hit ? RespOkay : RespSlvErr;
        end else if (slv_req_i.b_ready) begin
            b_valid_d = 1'b0;
        end
        if (rd_go) begin
            r_valid_d = 1'b1;
            r_data_d  = rd_hit ? mem_q[rd_idx] : '0;
            r_resp_d  = rd_hit ? RespOkay : RespSlvErr;
        end else if (slv_req_i.r_ready) begin
            r_valid_d = 1'b0;
        end
    end

    // B and R slot registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            b_valid_q <= 1'b0;
            b_resp_q  <= '0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            r_resp_q  <= '0;
        end else begin
            b_valid_q <= b_valid_d;
            b_resp_q  <= b_resp_d;
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
            r_resp_q  <= r_resp_d;
        end
    end

    // Response struct assembly
    always_comb begin
        slv_resp_o          = '0;
        slv_resp_o.aw_ready = wr_go;
        slv_resp_o.w_ready  = wr_go;
        slv_resp_o.b_valid  = b_valid_q;
        slv_resp_o.b.resp   = b_resp_q;
        slv_resp_o.ar_ready = ar_rdy;
        slv_resp_o.r_valid  = r_valid_q;
        slv_resp_o.r.data   = r_data_q;
        slv_resp_o.r.resp   = r_resp_q;
    end

endmodule
